// File: rtl/debounce_pkg.sv
// Shared constants and counter-width helper for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_NUM_CH         = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned DEFAULT_LONG_LIMIT     = 25000000;

    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/Debounce_Channel.sv
// One debounce channel: 2-flop sync, stability counter, edge pulses.
// Long-press hold counter is built only with DEBOUNCE_LONG_PRESS_EN.
module Debounce_Channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter logic        RESET_LEVEL    = 1'b0,
    parameter int unsigned LONG_LIMIT     = DEFAULT_LONG_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Bouncy,
    output logic o_Debounced,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Long
);

    if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
        $error("DEBOUNCE_LIMIT must be at least 2");
    end
    if (LONG_LIMIT < 1) begin : g_bad_long
        $error("LONG_LIMIT must be at least 1");
    end

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          differ, accept;

    assign differ = sync_q[1] ^ deb_q;
    assign accept = differ && (cnt_q == CNT_LAST);
    assign rise_d = accept & sync_q[1];
    assign fall_d = accept & ~sync_q[1];

    // Any agreeing cycle restarts the count, so glitches never accumulate.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (accept) begin
            deb_d = sync_q[1];
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {2{RESET_LEVEL}};
            cnt_q  <= '0;
            deb_q  <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_Bouncy};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_Debounced = deb_q;
    assign o_Rise      = rise_q;
    assign o_Fall      = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned   HW       = cnt_width(LONG_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_LIMIT);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    always_comb begin
        hold_d = '0;
        if (deb_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end

    // Saturation guarantees a single pulse per press.
    assign long_d = deb_q && (hold_q == HOLD_MAX - 1'b1);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign o_Long = long_q;
`else
    assign o_Long = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce_filter.sv
// Top: NUM_CH independent debounce channels.
// Define DEBOUNCE_LONG_PRESS_EN to enable long-press pulses on o_Long.
module multi_debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEFAULT_NUM_CH,
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter logic        RESET_LEVEL    = 1'b0,
    parameter int unsigned LONG_LIMIT     = DEFAULT_LONG_LIMIT
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Long
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        Debounce_Channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .RESET_LEVEL    (RESET_LEVEL),
            .LONG_LIMIT     (LONG_LIMIT)
        ) u_ch (
            .i_Clk       (i_Clk),
            .i_Rst_L     (i_Rst_L),
            .i_Bouncy    (i_Bouncy[ch]),
            .o_Debounced (o_Debounced[ch]),
            .o_Rise      (o_Rise[ch]),
            .o_Fall      (o_Fall[ch]),
            .o_Long      (o_Long[ch])
        );
    end

endmodule

// File: tb/tb_multi_debounce_filter.sv
// Scoreboard bench for multi_debounce_filter.
// Window model plus reset and wait checks.
module tb_multi_debounce_filter;

  localparam int N  = 4;
  localparam int L  = 5;
  localparam int LL = 20;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] deb;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] lng;
  } exp_t;

  logic         i_Clk = 1'b0;
  logic         i_Rst_L;
  logic [N-1:0] i_Bouncy;
  logic [N-1:0] o_Debounced;
  logic [N-1:0] o_Rise;
  logic [N-1:0] o_Fall;
  logic [N-1:0] o_Long;

  exp_t         sb[$];
  exp_t         m_e;
  exp_t         mon_e;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_deb;
  int           rise_at[N];
  int           k;
  int           remain[N];
  logic [N-1:0] rv;
  int           checks = 0;
  int           errors = 0;

  always #5 i_Clk = ~i_Clk;

  multi_debounce_filter #(
    .NUM_CH         (N),
    .DEBOUNCE_LIMIT (L),
    .RESET_LEVEL    (1'b0),
    .LONG_LIMIT     (LL)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Bouncy    (i_Bouncy),
    .o_Debounced (o_Debounced),
    .o_Rise      (o_Rise),
    .o_Fall      (o_Fall),
    .o_Long      (o_Long)
  );

  function automatic exp_t reset_exp();
    exp_t e;
    e.deb  = '0;
    e.rise = '0;
    e.fall = '0;
    e.lng  = '0;
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < L + 2; i++)
      hist.push_back('0);
    m_deb = '0;
    k     = 0;
    for (int ch = 0; ch < N; ch++)
      rise_at[ch] = -1000;
  endtask

  function automatic logic settles(
    input int ch
  );
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < L; j++) begin
      if (hist[j][ch] == m_deb[ch])
        ok = 1'b0;
    end
    return ok;
  endfunction

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      model_reset();
      sb.delete();
      sb.push_back(reset_exp());
    end else begin
      k = k + 1;
      hist.push_back(i_Bouncy);
      void'(hist.pop_front());
      m_e = reset_exp();
      for (int ch = 0; ch < N; ch++) begin
        m_e.lng[ch] = LONG_EN && m_deb[ch] &&
                      (k - rise_at[ch] == LL);
        if (settles(ch)) begin
          m_e.rise[ch] = !m_deb[ch];
          m_e.fall[ch] = m_deb[ch];
          if (!m_deb[ch])
            rise_at[ch] = k;
          m_deb[ch] = !m_deb[ch];
        end
      end
      m_e.deb = m_deb;
      sb.push_back(m_e);
    end
  end

  always @(negedge i_Clk) begin
    if (sb.size() > 0) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (o_Debounced !== mon_e.deb ||
          o_Rise !== mon_e.rise ||
          o_Fall !== mon_e.fall ||
          o_Long !== mon_e.lng) begin
        errors = errors + 1;
        $display("FAIL outputs t=%0t got %b %b %b %b want %b %b %b %b",
                 $time, o_Debounced, o_Rise, o_Fall, o_Long,
                 mon_e.deb, mon_e.rise, mon_e.fall, mon_e.lng);
      end
    end
  end

  task automatic chk_reset();
    #1;
    checks = checks + 1;
    if (o_Debounced !== '0 || o_Rise !== '0 ||
        o_Fall !== '0 || o_Long !== '0) begin
      errors = errors + 1;
      $display("FAIL reset t=%0t deb=%b rise=%b fall=%b long=%b",
               $time, o_Debounced, o_Rise, o_Fall, o_Long);
    end
  endtask

  task automatic wait_deb(
    input int   ch,
    input logic val,
    input int   max
  );
    int n;
    n = 0;
    while (o_Debounced[ch] !== val && n < max) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    checks = checks + 1;
    if (o_Debounced[ch] !== val) begin
      errors = errors + 1;
      $display("FAIL wait expired t=%0t ch=%0d want %b",
               $time, ch, val);
    end
  endtask

  task automatic drive(
    input logic [N-1:0] v,
    input int           n
  );
    i_Bouncy = v;
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Bouncy = '0;
    chk_reset();
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;

    i_Bouncy = 4'b0001;
    wait_deb(0, 1'b1, 12);
    drive(4'b0001, 5);
    for (int i = 0; i < 10; i++)
      drive(i_Bouncy ^ 4'b0010, 1);
    drive(4'b0001, 12);

    drive(4'b0101, 4);
    drive(4'b0001, 1);
    drive(4'b0101, 12);

    drive(4'b0000, 12);
    drive(4'b1111, 12);
    drive(4'b0000, 12);

    drive(4'b1000, 45);
    drive(4'b0000, 12);

    drive(4'b0001, 3);
    i_Rst_L = 1'b0;
    chk_reset();
    drive(4'b0001, 3);
    i_Rst_L = 1'b1;
    wait_deb(0, 1'b1, 12);
    drive(4'b0001, 5);

    for (int ch = 0; ch < N; ch++)
      remain[ch] = 0;
    for (int c = 0; c < 400; c++) begin
      rv = i_Bouncy;
      for (int ch = 0; ch < N; ch++) begin
        if (remain[ch] == 0) begin
          rv[ch] = 1'($urandom);
          remain[ch] = ($urandom_range(0, 4) == 0) ?
                       int'($urandom_range(18, 30)) :
                       int'($urandom_range(1, 7));
        end
        remain[ch] = remain[ch] - 1;
      end
      drive(rv, 1);
    end

    drive(4'b0000, 40);
    @(negedge i_Clk);
    @(negedge i_Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debounce_filter.md
MULTI_DEBOUNCE_FILTER -- requirements
Module: Multi_Debounce_Filter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, giving the cycles of stable, differing input needed to accept a level (legal range 2..2^24).
REQ-003 The block SHALL have parameter RESET_LEVEL, default 1'b0, giving the debounced level of every channel after reset.
REQ-004 The block SHALL have parameter LONG_LIMIT, default 25000000, giving the cycles the debounced level must stay high for a long-press event (used only with LONG_PRESS_EN).
REQ-005 i_Clk  input  1  single clock; all state is on its rising edge.
REQ-006 i_Rst_L  input  1  reset, asynchronous assert and active-low.
REQ-007 i_Bouncy  input  NUM_CH  raw asynchronous inputs, one bit per channel.
REQ-008 o_Debounced  output  NUM_CH  filtered level per channel.
REQ-009 o_Rise  output  NUM_CH  one-cycle pulse when o_Debounced[ch] goes 0->1.
REQ-010 o_Fall  output  NUM_CH  one-cycle pulse when o_Debounced[ch] goes 1->0.
REQ-011 o_Long  output  NUM_CH  one-cycle long-press pulse; constant 0 without LONG_PRESS_EN.

Function
REQ-012 Each channel SHALL pass i_Bouncy[ch] through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL keep a counter of width $clog2(DEBOUNCE_LIMIT); it SHALL increment while the synchronized bit differs from o_Debounced[ch].
REQ-014 The counter SHALL clear to 0 on any cycle where the synchronized bit equals o_Debounced[ch]. A single-cycle glitch therefore restarts the count.
REQ-015 When the counter equals DEBOUNCE_LIMIT-1 and the bits still differ, the channel SHALL, on the next edge, load o_Debounced[ch] with the synchronized bit and clear the counter.
REQ-016 The latency from the first edge sampling a stable new i_Bouncy level to the o_Debounced change SHALL be exactly DEBOUNCE_LIMIT+2 clock edges.
REQ-017 o_Rise[ch] and o_Fall[ch] SHALL be registered and asserted in the same cycle o_Debounced[ch] shows its new value, for exactly one cycle.
REQ-018 o_Rise[ch] and o_Fall[ch] SHALL never be high in the same cycle.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 Counters SHALL never wrap; the counter value SHALL never exceed DEBOUNCE_LIMIT-1.

Reset
REQ-021 On i_Rst_L low, synchronizer flops and o_Debounced SHALL take RESET_LEVEL, counters SHALL clear, and o_Rise, o_Fall and o_Long SHALL be 0, all immediately.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, counting SHALL restart from 0 with no spurious pulses.
REQ-023 Reset release SHALL be synchronized externally; the block SHALL assume release is synchronous to i_Clk.

Configuration
REQ-024 Macro DEBOUNCE_LONG_PRESS_EN defined: each channel SHALL have a hold counter of width $clog2(LONG_LIMIT+1), cleared while o_Debounced[ch] is 0.
REQ-025 The hold counter SHALL increment while o_Debounced[ch] is 1 and SHALL saturate at LONG_LIMIT.
REQ-026 o_Long[ch] SHALL pulse once, on the cycle the hold counter reaches LONG_LIMIT.
REQ-027 Macro undefined: no hold counters SHALL exist and o_Long SHALL be tied to 0.

Structure
REQ-028 Package debounce_pkg SHALL hold the counter-width helper function and the default-limit constants.
REQ-029 Per-channel logic SHALL be a sub-module Debounce_Channel, instantiated NUM_CH times by a generate loop.
REQ-030 The top level SHALL contain only the generate loop and port concatenation.

Verification (DEBOUNCE_LIMIT=5, LONG_LIMIT=20, NUM_CH=4, RESET_LEVEL=0)
REQ-031 Raise i_Bouncy[0] and hold -> o_Debounced[0] rises exactly 7 edges later, with a one-cycle o_Rise[0] and o_Fall stuck at 0.
REQ-032 Toggle i_Bouncy[1] every cycle for 10 cycles, then hold at 0 -> o_Debounced[1] stays 0 with no pulses.
REQ-033 Hold i_Bouncy[2] high 4 cycles, low 1 cycle, high again -> o_Debounced[2] rises 7 edges after the final rise, not before.
REQ-034 Raise all four channels together -> all four o_Rise bits pulse in the same cycle; lowering them later gives four o_Fall pulses in one cycle.
REQ-035 With DEBOUNCE_LONG_PRESS_EN, hold channel 3 high -> o_Long[3] pulses once, 20 cycles after o_Debounced[3] rises, and never again until a fall.
REQ-036 Assert i_Rst_L low 3 cycles into a count -> outputs return to 0 at once; after release the full 7-edge latency applies.
